// File: rtl/matrix_stream_adapter.sv
// Streams nine row-major elements into a 3x3 matrix for a decomposition core,
// launches the core, then streams its 3x3 result back out row-major.
module matrix_stream_adapter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [0:2][0:2][DATA_WIDTH-1:0]        ip_matrix,
    output logic                                   start,
    input  logic signed [0:2][0:2][DATA_WIDTH-1:0] op_matrix,
    input  logic                                   done,
    output logic signed [DATA_WIDTH-1:0]           out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy,
    output logic                                   err
);
    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] KICK   = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] UNLOAD = 2'd3;
    localparam int         CW     = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]                 state;
    logic [3:0]                 idx;
    logic [CW-1:0]              wait_cnt;
    logic [8:0][DATA_WIDTH-1:0] mat_q;
    logic [8:0][DATA_WIDTH-1:0] res_buf;
    logic [8:0][DATA_WIDTH-1:0] op_flat;
    logic                       in_fire;
    logic                       out_fire;

    // Flat row-major views of the 3x3 ports; entry r*3+c holds element [r][c].
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign ip_matrix[r][c]  = mat_q[r*3+c];
            assign op_flat[r*3+c]   = op_matrix[r][c];
        end
    end

    assign in_ready  = (state == LOAD) && !RST;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == UNLOAD);
    assign out_fire  = out_valid && out_ready;
    assign start     = (state == KICK);
    assign busy      = (state != LOAD);
    assign out_data  = out_valid ? res_buf[idx] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= LOAD;
            idx      <= '0;
            wait_cnt <= '0;
            mat_q    <= '0;
            res_buf  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        mat_q[idx] <= in_data;
                        if (idx == 4'd8) begin
                            idx   <= '0;
                            state <= KICK;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                KICK: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (done) begin
                        res_buf <= op_flat;
                        state   <= UNLOAD;
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        err      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        if (idx == 4'd8) begin
                            idx   <= '0;
                            state <= LOAD;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_stream_adapter.sv
// Randomized bench: queues of expected matrix/result elements drive and judge
// each load / wait / unload transaction, plus timeout and mid-flight resets.
module tb_matrix_stream_adapter;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                           CLK = 1'b0;
    logic                           RST;
    logic [DW-1:0]                  in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [0:2][0:2][DW-1:0]        ip_matrix;
    logic                           start;
    logic signed [0:2][0:2][DW-1:0] op_matrix;
    logic                           done;
    logic signed [DW-1:0]           out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           busy;
    logic                           err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] mat_exp [9];
    logic [DW-1:0] res_exp [9];

    always #5 CLK = ~CLK;

    matrix_stream_adapter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ip_matrix(ip_matrix), .start(start),
        .op_matrix(op_matrix), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic junk_op();
        for (int i = 0; i < 9; i++) op_matrix[i/3][i%3] = $urandom;
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 9; i++) begin
            mat_exp[i] = $urandom;
            res_exp[i] = $urandom;
        end
    endtask

    task automatic chk_matrix(input string tag);
        for (int i = 0; i < 9; i++) chk(tag, ip_matrix[i/3][i%3], mat_exp[i]);
    endtask

    // gap < 0: random in_valid; otherwise in_valid once every gap+1 cycles.
    // Returns at the negedge of the cycle the start pulse is expected in.
    task automatic load9(input int gap, input bit junk_done);
        int k = 0;
        int cyc = 0;
        while (k < 9 && cyc < 300) begin
            @(negedge CLK);
            chk("ld_start", start, 1'b0);
            chk("ld_ovalid", out_valid, 1'b0);
            in_valid  = (gap < 0) ? ($urandom_range(0, 1) == 1) : (cyc % (gap + 1) == 0);
            in_data   = in_valid ? mat_exp[k] : $urandom;
            done      = junk_done && ($urandom_range(0, 1) == 1);
            junk_op();
            if (in_valid && in_ready) k++;
            cyc++;
        end
        if (k < 9) chk("ld_bound", k, 9);
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = $urandom;
        done     = junk_done;
        junk_op();
        chk("kick_start", start, 1'b1);
        chk("kick_busy", busy, 1'b1);
        chk("kick_irdy", in_ready, 1'b0);
        chk_matrix("kick_mat");
    endtask

    task automatic wait_done(input int delay);
        for (int d = 0; d < delay; d++) begin
            @(negedge CLK);
            done     = 1'b0;
            in_valid = 1'b1;
            in_data  = $urandom;
            chk("wt_start", start, 1'b0);
            chk("wt_ovalid", out_valid, 1'b0);
            chk("wt_busy", busy, 1'b1);
        end
        @(negedge CLK);
        chk("wt_start", start, 1'b0);
        done = 1'b1;
        for (int i = 0; i < 9; i++) op_matrix[i/3][i%3] = res_exp[i];
        chk_matrix("wt_mat");
    endtask

    // mode 0: out_ready high; 1: toggles starting low; 2: random
    task automatic unload9(input int mode);
        int k = 0;
        int cyc = 0;
        while (k < 9 && cyc < 300) begin
            @(negedge CLK);
            done = ($urandom_range(0, 1) == 1);
            junk_op();
            chk("ul_valid", out_valid, 1'b1);
            chk("ul_data", out_data, res_exp[k]);
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 1) == 1);
            in_valid  = !(out_ready && k == 8);
            in_data   = $urandom;
            if (out_valid && out_ready) k++;
            cyc++;
        end
        if (mode == 0) chk("ul_cycles", cyc, 9);
        if (mode == 1) chk("ul_cycles_tgl", cyc, 18);
        @(negedge CLK);
        done      = 1'b0;
        in_valid  = 1'b0;
        out_ready = $urandom_range(0, 1);
        chk("post_ovalid", out_valid, 1'b0);
        chk("post_irdy", in_ready, 1'b1);
        chk("post_busy", busy, 1'b0);
    endtask

    task automatic txn(input int gap, input int mode, input int delay, input bit junk);
        load9(gap, junk);
        wait_done(delay);
        unload9(mode);
    endtask

    initial begin
        RST = 1'b1; in_data = '0; in_valid = 1'b0; done = 1'b0; out_ready = 1'b0;
        op_matrix = '0;
        repeat (2) @(negedge CLK);
        chk("rst_irdy", in_ready, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_odata", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        for (int i = 0; i < 9; i++) mat_exp[i] = '0;
        chk_matrix("rst_mat");
        RST = 1'b0;
        #1 chk("rst_rel_irdy", in_ready, 1'b1);

        // 1..9 in, -1..-9 out at full rate
        for (int i = 0; i < 9; i++) begin
            mat_exp[i] = i + 1;
            res_exp[i] = -(i + 1);
        end
        txn(0, 0, 2, 1'b0);

        // sparse input, stalling output
        rand_vals();
        txn(2, 1, 0, 1'b1);

        // timeout: no done for TO wait cycles
        rand_vals();
        load9(0, 1'b0);
        for (int w = 0; w < TO; w++) begin
            @(negedge CLK);
            done = 1'b0; in_valid = 1'b1; in_data = $urandom;
            chk("to_err_pre", err, 1'b0);
            chk("to_ovalid", out_valid, 1'b0);
            chk("to_busy", busy, 1'b1);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        chk("to_err", err, 1'b1);
        chk("to_busy_post", busy, 1'b0);
        chk("to_irdy", in_ready, 1'b1);
        chk("to_ovalid_post", out_valid, 1'b0);
        rand_vals();
        txn(-1, 2, 5, 1'b1);
        chk("err_sticky", err, 1'b1);

        for (int t = 0; t < 6; t++) begin
            rand_vals();
            txn(-1, 2, $urandom_range(0, TO - 2), 1'b1);
        end

        // reset after 5 accepted inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            in_valid = 1'b1; in_data = 100 + i;
        end
        @(negedge CLK);
        RST = 1'b1; in_data = $urandom;
        @(negedge CLK);
        chk("mid_rst_irdy", in_ready, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        for (int i = 0; i < 9; i++) mat_exp[i] = '0;
        chk_matrix("mid_rst_mat");
        RST = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mat_exp[i] = 10 + i;
            res_exp[i] = $urandom;
        end
        txn(0, 2, 3, 1'b0);

        // reset mid-wait: a late done must not produce output
        rand_vals();
        load9(0, 1'b0);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            done = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            done = 1'b1; junk_op();
            chk("rw_ovalid", out_valid, 1'b0);
            chk("rw_busy", busy, 1'b0);
            chk("rw_start", start, 1'b0);
        end
        @(negedge CLK);
        done = 1'b0;
        rand_vals();
        txn(-1, 1, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
